// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage with IF/ID register and one-entry skid.
// One fetch in flight; redirects squash stale fetches and the IF/ID slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        id_flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        sk_valid;
    logic [31:0] sk_pc;
    logic [31:0] sk_instr;
    logic        req_fire;
    logic        rsp_take;
    logic        slot_free;
    logic        unused_bits;

    assign unused_bits   = ^redirect_pc[1:0];
    assign imem_req_addr = pc;
    assign id_flush      = !if_id_valid;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_take      = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign slot_free     = !if_id_valid || !id_stall;

    // Request issue and next-state selection
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req_valid = !rst && !sk_valid && !redirect_valid;
                if (imem_req_valid && imem_req_ready)
                    state_next = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid)
                    state_next = FETCH;
                else if (redirect_valid)
                    state_next = DROP;
            end
            DROP: begin
                if (imem_rsp_valid)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    // PC and outstanding-request address
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= 32'h0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
        end
    end

    // IF/ID slot and skid buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= 32'h0;
            sk_valid    <= 1'b0;
            sk_pc       <= 32'h0;
            sk_instr    <= 32'h0;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            sk_valid    <= 1'b0;
        end else if (slot_free) begin
            if (sk_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= sk_pc;
                if_id_instr <= sk_instr;
                sk_valid    <= 1'b0;
            end else if (rsp_take) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_instr <= imem_rsp_data;
            end else begin
                if_id_valid <= 1'b0;
            end
        end else if (rsp_take) begin
            sk_valid <= 1'b1;
            sk_pc    <= req_pc;
            sk_instr <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
// Memory model returns address-tagged words after a random latency.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] TAG    = 32'h1357_9BDF;
    localparam int          NCYC   = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        id_flush;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: queue of delivered {pc, instr}, front = IF/ID
    logic [63:0] m_q[$];
    logic [31:0] m_pc, m_req_pc, m_last_pc, m_last_instr;
    bit          m_out, m_stale;

    // memory model
    int          cnt;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .id_flush       (id_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc         = RST_PC;
        m_req_pc     = 32'h0;
        m_out        = 0;
        m_stale      = 0;
        m_last_pc    = 32'h0;
        m_last_instr = 32'h0;
        m_q.delete();
    endtask

    task automatic model_step(input bit exp_req);
        if (rst) begin
            model_reset();
            return;
        end
        if (redirect_valid) begin
            m_q.delete();
            if (m_out) begin
                if (imem_rsp_valid) begin
                    m_out   = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (m_q.size() > 0 && !id_stall)
                void'(m_q.pop_front());
            if (m_out && imem_rsp_valid) begin
                if (!m_stale)
                    m_q.push_back({m_req_pc, imem_rsp_data});
                m_out   = 0;
                m_stale = 0;
            end
            if (exp_req && imem_req_ready) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1;
            end
        end
        if (m_q.size() > 0)
            {m_last_pc, m_last_instr} = m_q[0];
    endtask

    initial begin
        int stall_pct[4] = '{0, 40, 20, 60};
        int ready_pct[4] = '{100, 70, 80, 50};
        int redir_pct[4] = '{0, 2, 8, 3};
        bit          exp_req;
        bit          fire;
        logic [31:0] addr;
        int          ph;

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        cnt            = -1;
        pend_addr      = 32'h0;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            ph  = i / (NCYC / 4);
            rst = (i < 1) || ($urandom_range(0, 399) == 0);
            redirect_valid = !rst &&
                ($urandom_range(0, 99) < redir_pct[ph]);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else
                redirect_pc = $urandom;
            id_stall       = $urandom_range(0, 99) < stall_pct[ph];
            imem_req_ready = $urandom_range(0, 99) < ready_pct[ph];
            imem_rsp_valid = (cnt == 0);
            imem_rsp_data  = (cnt == 0) ? (pend_addr ^ TAG) : $urandom;
            #1;
            exp_req = !rst && !m_out && m_q.size() < 2 && !redirect_valid;
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (exp_req)
                chk("req_addr", imem_req_addr, m_pc);
            chk("id_flush", {31'b0, id_flush},
                {31'b0, m_q.size() == 0});
            fire = imem_req_valid && imem_req_ready;
            addr = imem_req_addr;
            model_step(exp_req);

            @(posedge clk);
            if (rst) begin
                cnt = -1;
            end else begin
                if (cnt == 0)
                    cnt = -1;
                else if (cnt > 0)
                    cnt--;
                if (fire) begin
                    cnt       = (ph == 0) ? 0 : $urandom_range(0, 2);
                    pend_addr = addr;
                end
            end
            #1;
            chk("if_id_valid", {31'b0, if_id_valid},
                {31'b0, m_q.size() > 0});
            chk("if_id_pc", if_id_pc, m_last_pc);
            chk("if_id_instr", if_id_instr, m_last_instr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
